exc_unit: RTL and testbench

- Parametrised exception/interrupt unit for the MIPS core: collects NCAUSE cause lines, latches external ones, masks by SR, picks the highest-priority cause, and drives jisr.
- Owns the special-purpose register file (SR, ESR, ECA, EPC, EDPC, EDATA, MODE, EMODE).
- Has an ISR-entry flush sequencer, rfe return, and a fatal-halt state.
- Sits between the decode/execute stage (cause sources, commit strobe) and PC/control logic (jisr, epc, mode).

---
 rtl/exc_pkg.sv | 35 +++
 rtl/exc_unit_if.sv | 38 +++
 rtl/exc_prio_enc.sv | 24 ++
 rtl/exc_unit.sv | 153 +++++++++++++++
 tb/tb_exc_unit.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/exc_pkg.sv
// Shared definitions for the exception unit: default sizes, SPR indices,
// named internal cause positions and the sequencer state encoding.
package exc_pkg;

   localparam int unsigned NCAUSE_DEF = 23;
   localparam int unsigned NINT_DEF   = 7;
   localparam int unsigned W_DEF      = 32;
   localparam int unsigned SPR_SEL_W  = 3;

   // Special-purpose register indices (reg_sel encoding)
   localparam logic [SPR_SEL_W-1:0] SPR_SR    = 3'd0;
   localparam logic [SPR_SEL_W-1:0] SPR_ESR   = 3'd1;
   localparam logic [SPR_SEL_W-1:0] SPR_ECA   = 3'd2;
   localparam logic [SPR_SEL_W-1:0] SPR_EPC   = 3'd3;
   localparam logic [SPR_SEL_W-1:0] SPR_EDPC  = 3'd4;
   localparam logic [SPR_SEL_W-1:0] SPR_EDATA = 3'd5;
   localparam logic [SPR_SEL_W-1:0] SPR_MODE  = 3'd6;
   localparam logic [SPR_SEL_W-1:0] SPR_EMODE = 3'd7;

   // Internal cause lines, lowest index wins
   localparam int unsigned C_RESET = 0;
   localparam int unsigned C_ILL   = 1;
   localparam int unsigned C_MAL   = 2;
   localparam int unsigned C_PFF   = 3;
   localparam int unsigned C_PFLS  = 4;
   localparam int unsigned C_TRAP  = 5;
   localparam int unsigned C_OVF   = 6;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      HALT  = 2'd2
   } exc_state_e;

endpackage

// File: rtl/exc_unit_if.sv
// Bus between the pipeline (master: cause sources, commit, SPR access)
// and the exception unit (slave: jisr, cause status, SPR read, mode).
interface exc_unit_if
   import exc_pkg::*;
#(
   parameter int unsigned NCAUSE = NCAUSE_DEF,
   parameter int unsigned W      = W_DEF
);
   localparam int unsigned IL_W = $clog2(NCAUSE);

   logic [NCAUSE-1:0]    ca;
   logic                 ue;
   logic [W-1:0]         pc;
   logic [W-1:0]         next_pc;
   logic [W-1:0]         ea;
   logic                 rfe;
   logic                 sprw;
   logic [SPR_SEL_W-1:0] reg_sel;
   logic [W-1:0]         data_in;

   logic [W-1:0]         spr_out;
   logic                 jisr;
   logic [NCAUSE-1:0]    mca;
   logic [IL_W-1:0]      il;
   logic                 mode;
   logic                 busy;
   logic                 abort;

   modport master (
      output ca, ue, pc, next_pc, ea, rfe, sprw, reg_sel, data_in,
      input  spr_out, jisr, mca, il, mode, busy, abort
   );

   modport slave (
      input  ca, ue, pc, next_pc, ea, rfe, sprw, reg_sel, data_in,
      output spr_out, jisr, mca, il, mode, busy, abort
   );
endinterface

// File: rtl/exc_prio_enc.sv
// Lowest-index-wins priority encoder.
//   req   : request vector, bit 0 highest priority
//   idx   : index of the winning request (0 when none)
//   valid : any request present
module exc_prio_enc #(
   parameter int unsigned N  = 23,
   parameter int unsigned IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   output logic [IW-1:0] idx,
   output logic          valid
);

   // Scan downward so the lowest set index is assigned last
   always_comb begin
      idx = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (req[i]) idx = IW'(i);
      end
   end

   assign valid = |req;

endmodule

// File: rtl/exc_unit.sv
// Exception/interrupt unit: latches external causes, masks them by SR,
// selects the winning cause, raises jisr on commit, saves the exception
// frame into the SPR file and sequences ISR entry (FLUSH), rfe and fatal HALT.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : exc_unit_if slave port (causes, commit info, SPR access in;
//              spr_out, jisr, mca, il, mode, busy, abort out)
module exc_unit
   import exc_pkg::*;
#(
   parameter int unsigned       NCAUSE       = NCAUSE_DEF,
   parameter int unsigned       NINT         = NINT_DEF,
   parameter logic [NCAUSE-1:0] REPEAT_MASK  = 'h00006A,
   parameter logic [NCAUSE-1:0] FATAL_MASK   = 'h000001,
   parameter int unsigned       FLUSH_CYCLES = 2,
   parameter int unsigned       W            = W_DEF
) (
   input  logic       clk,
   input  logic       rst,
   exc_unit_if.slave  bus
);

   localparam int unsigned IL_W  = $clog2(NCAUSE);
   localparam int unsigned NEXT  = NCAUSE - NINT;
   localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   exc_state_e        state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [NEXT-1:0]   pend_q;
   logic [W-1:0]      sr_q, esr_q, eca_q, epc_q, edpc_q, edata_q;
   logic              mode_q, emode_q;
   logic              busy_q, abort_q;

   logic [NCAUSE-1:0] eff_c;
   logic [NCAUSE-1:0] mca_c;
   logic [IL_W-1:0]   il_c;
   logic              any_c;
   logic              jisr_c;
   logic [W-1:0]      spr_c;

   // External causes are sticky and maskable; internal ones pass straight through
   assign eff_c = {pend_q | bus.ca[NCAUSE-1:NINT], bus.ca[NINT-1:0]};
   assign mca_c = eff_c & {sr_q[NCAUSE-1:NINT], {NINT{1'b1}}};

   exc_prio_enc #(
      .N  (NCAUSE),
      .IW (IL_W)
   ) u_prio (
      .req   (mca_c),
      .idx   (il_c),
      .valid (any_c)
   );

   assign jisr_c = (state_q == RUN) && bus.ue && any_c;

   // SPR read returns the pre-edge value
   always_comb begin
      spr_c = '0;
      unique case (bus.reg_sel)
         SPR_SR:    spr_c = sr_q;
         SPR_ESR:   spr_c = esr_q;
         SPR_ECA:   spr_c = eca_q;
         SPR_EPC:   spr_c = epc_q;
         SPR_EDPC:  spr_c = edpc_q;
         SPR_EDATA: spr_c = edata_q;
         SPR_MODE:  spr_c = W'(mode_q);
         SPR_EMODE: spr_c = W'(emode_q);
      endcase
   end

   // Sequencer and SPR file; priority on an edge is jisr > rfe > sprw
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
         pend_q  <= '0;
         sr_q    <= W'({NCAUSE{1'b1}});
         esr_q   <= '0;
         eca_q   <= '0;
         epc_q   <= '0;
         edpc_q  <= '0;
         edata_q <= '0;
         mode_q  <= 1'b0;
         emode_q <= 1'b0;
         busy_q  <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         unique case (state_q)
            RUN: begin
               pend_q <= pend_q | bus.ca[NCAUSE-1:NINT];
               if (jisr_c) begin
                  esr_q   <= sr_q;
                  sr_q    <= '0;
                  eca_q   <= W'(mca_c);
                  epc_q   <= REPEAT_MASK[il_c] ? bus.pc : bus.next_pc;
                  edpc_q  <= bus.pc;
                  edata_q <= bus.ea;
                  emode_q <= mode_q;
                  mode_q  <= 1'b0;
                  pend_q  <= '0;
                  if (FATAL_MASK[il_c]) begin
                     state_q <= HALT;
                     abort_q <= 1'b1;
                  end else begin
                     state_q <= FLUSH;
                     busy_q  <= 1'b1;
                     cnt_q   <= CNT_W'(FLUSH_CYCLES - 1);
                  end
               end else if (bus.ue && bus.rfe) begin
                  sr_q   <= esr_q;
                  mode_q <= emode_q;
               end else if (bus.ue && bus.sprw) begin
                  unique case (bus.reg_sel)
                     SPR_SR:    sr_q    <= bus.data_in;
                     SPR_ESR:   esr_q   <= bus.data_in;
                     SPR_ECA:   eca_q   <= W'(bus.data_in[NCAUSE-1:0]);
                     SPR_EPC:   epc_q   <= bus.data_in;
                     SPR_EDPC:  edpc_q  <= bus.data_in;
                     SPR_EDATA: edata_q <= bus.data_in;
                     SPR_MODE:  mode_q  <= bus.data_in[0];
                     SPR_EMODE: emode_q <= bus.data_in[0];
                  endcase
               end
            end
            FLUSH: begin
               pend_q <= pend_q | bus.ca[NCAUSE-1:NINT];
               if (cnt_q == '0) begin
                  state_q <= RUN;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            HALT: begin
               // Frozen until reset
            end
            default: begin
               state_q <= HALT;
               abort_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.spr_out = spr_c;
   assign bus.jisr    = jisr_c;
   assign bus.mca     = mca_c;
   assign bus.il      = il_c;
   assign bus.mode    = mode_q;
   assign bus.busy    = busy_q;
   assign bus.abort   = abort_q;

endmodule

// File: tb/tb_exc_unit.sv
// Directed self-checking bench for exc_unit with hand-computed expectations.
module tb_exc_unit;
   import exc_pkg::*;

   localparam int unsigned NC    = 23;
   localparam logic [22:0] RMASK = 23'h00006A;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   exc_unit_if #(.NCAUSE(NC), .W(32)) bus ();

   exc_unit #(
      .NCAUSE       (NC),
      .NINT         (7),
      .REPEAT_MASK  (RMASK),
      .FATAL_MASK   (23'h000001),
      .FLUSH_CYCLES (2),
      .W            (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.ca      = '0;
      bus.ue      = 1'b0;
      bus.rfe     = 1'b0;
      bus.sprw    = 1'b0;
      bus.reg_sel = SPR_SR;
      bus.data_in = '0;
      bus.pc      = '0;
      bus.next_pc = '0;
      bus.ea      = '0;
   endtask

   task automatic rd(input logic [2:0] sel, input string tag, input logic [31:0] exp);
      bus.reg_sel = sel;
      #1;
      check(tag, bus.spr_out, exp);
   endtask

   task automatic wr(input logic [2:0] sel, input logic [31:0] data);
      bus.ue      = 1'b1;
      bus.sprw    = 1'b1;
      bus.reg_sel = sel;
      bus.data_in = data;
      tick();
      bus.ue   = 1'b0;
      bus.sprw = 1'b0;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      #1;
      check("rst_jisr",  32'(bus.jisr),  32'h0);
      check("rst_busy",  32'(bus.busy),  32'h0);
      check("rst_abort", 32'(bus.abort), 32'h0);
      check("rst_mode",  32'(bus.mode),  32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Commit with no causes
      bus.ue = 1'b1;
      #1;
      check("idle_jisr", 32'(bus.jisr), 32'h0);
      check("idle_mca",  32'(bus.mca),  32'h0);
      check("idle_il",   32'(bus.il),   32'h0);
      bus.ue = 1'b0;
      rd(SPR_SR,  "rst_sr",  32'h007F_FFFF);
      rd(SPR_ESR, "rst_esr", 32'h0);
      tick();

      // Trap on commit, then FLUSH with rfe held (must be ignored)
      bus.ca[C_TRAP] = 1'b1;
      bus.ue      = 1'b1;
      bus.pc      = 32'h100;
      bus.next_pc = 32'h104;
      bus.ea      = 32'hA5A5_0000;
      #1;
      check("trap_jisr", 32'(bus.jisr), 32'h1);
      check("trap_il",   32'(bus.il),   32'd5);
      check("trap_mca",  32'(bus.mca),  32'h20);
      tick();
      bus.rfe = 1'b1;
      #1;
      check("flush_a_jisr", 32'(bus.jisr), 32'h0);
      check("flush_a_busy", 32'(bus.busy), 32'h1);
      rd(SPR_EPC, "trap_epc", RMASK[5] ? 32'h100 : 32'h104);
      rd(SPR_ECA, "trap_eca", 32'h20);
      rd(SPR_SR,  "trap_sr",  32'h0);
      rd(SPR_ESR, "trap_esr", 32'h007F_FFFF);
      tick();
      check("flush_b_busy", 32'(bus.busy), 32'h1);
      check("flush_b_jisr", 32'(bus.jisr), 32'h0);
      rd(SPR_EDPC,  "trap_edpc",  32'h100);
      rd(SPR_EDATA, "trap_edata", 32'hA5A5_0000);
      tick();
      idle();
      #1;
      check("flush_end_busy", 32'(bus.busy), 32'h0);
      rd(SPR_SR, "flush_rfe_ignored", 32'h0);
      tick();

      // Masked external cause latches, fires after SR opens it
      bus.ca[12] = 1'b1;
      #1;
      check("ext_masked_mca", 32'(bus.mca), 32'h0);
      tick();
      bus.ca = '0;
      bus.ue = 1'b1; bus.sprw = 1'b1; bus.reg_sel = SPR_SR; bus.data_in = 32'hFFFF_FFFF;
      #1;
      check("ext_prewr_jisr", 32'(bus.jisr), 32'h0);
      tick();
      bus.ue = 1'b0; bus.sprw = 1'b0;
      bus.pc = 32'h300; bus.next_pc = 32'h304; bus.ea = 32'h3300;
      #1;
      check("ext_pend_mca",   32'(bus.mca),  32'h1000);
      check("ext_noue_jisr",  32'(bus.jisr), 32'h0);
      bus.ue = 1'b1;
      #1;
      check("ext_jisr", 32'(bus.jisr), 32'h1);
      check("ext_il",   32'(bus.il),   32'd12);
      tick();
      idle();
      rd(SPR_EPC, "ext_epc", 32'h304);
      rd(SPR_ECA, "ext_eca", 32'h1000);
      rd(SPR_ESR, "ext_esr", 32'hFFFF_FFFF);
      tick();
      tick();
      wr(SPR_SR, 32'hFFFF_FFFF);
      #1;
      check("ext_pend_clr", 32'(bus.mca), 32'h0);

      // Two simultaneous causes: lower index wins, both reported in ECA
      bus.ca[3] = 1'b1; bus.ca[9] = 1'b1;
      bus.ue = 1'b1; bus.pc = 32'h200; bus.next_pc = 32'h204;
      #1;
      check("two_jisr", 32'(bus.jisr), 32'h1);
      check("two_il",   32'(bus.il),   32'd3);
      check("two_mca",  32'(bus.mca),  32'h208);
      tick();
      idle();
      rd(SPR_EPC, "two_epc", 32'h200);
      rd(SPR_ECA, "two_eca", 32'h208);
      tick();
      tick();

      // Continue-type internal cause with SR = 0 (internal is never masked)
      bus.ca[C_PFLS] = 1'b1;
      bus.ue = 1'b1; bus.pc = 32'h400; bus.next_pc = 32'h408;
      #1;
      check("cont_jisr", 32'(bus.jisr), 32'h1);
      tick();
      idle();
      rd(SPR_EPC, "cont_epc", 32'h408);
      rd(SPR_ECA, "cont_eca", 32'h10);
      tick();
      tick();

      // rfe restores SR and mode
      wr(SPR_ESR, 32'h1000);
      wr(SPR_EMODE, 32'hFFFF_FFFF);
      rd(SPR_EMODE, "emode_wr", 32'h1);
      bus.ue = 1'b1; bus.rfe = 1'b1;
      tick();
      idle();
      #1;
      check("rfe_mode", 32'(bus.mode), 32'h1);
      rd(SPR_SR, "rfe_sr", 32'h1000);

      // rfe beats sprw on the same edge
      wr(SPR_ESR, 32'h2000);
      bus.ue = 1'b1; bus.rfe = 1'b1; bus.sprw = 1'b1;
      bus.reg_sel = SPR_SR; bus.data_in = 32'h5555;
      tick();
      idle();
      rd(SPR_SR, "rfe_over_sprw", 32'h2000);
      wr(SPR_MODE, 32'h2);
      #1;
      check("mode_wr_bit0", 32'(bus.mode), 32'h0);
      wr(SPR_ECA, 32'hFFFF_FFFF);
      rd(SPR_ECA, "eca_wr_trunc", 32'h007F_FFFF);
      tick();

      // Fatal cause enters HALT; later causes and writes are ignored
      bus.ca[C_RESET] = 1'b1;
      bus.ue = 1'b1; bus.pc = 32'h500; bus.next_pc = 32'h504;
      #1;
      check("fatal_jisr", 32'(bus.jisr), 32'h1);
      check("fatal_il",   32'(bus.il),   32'd0);
      tick();
      bus.ca = '0;
      bus.ca[C_TRAP] = 1'b1;
      #1;
      check("halt_abort", 32'(bus.abort), 32'h1);
      check("halt_busy",  32'(bus.busy),  32'h0);
      check("halt_jisr",  32'(bus.jisr),  32'h0);
      bus.ca = '0;
      bus.sprw = 1'b1; bus.reg_sel = SPR_SR; bus.data_in = 32'h1234;
      tick();
      idle();
      rd(SPR_SR, "halt_sprw_ignored", 32'h0);
      #2 rst = 1'b1;
      #1;
      check("async_rst_abort", 32'(bus.abort), 32'h0);
      rd(SPR_SR, "async_rst_sr", 32'h007F_FFFF);
      tick();
      rst = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
